// File: rtl/execute_cc_stage.sv
// Y86-64 execute-stage back half: condition-code register, branch/cmov
// condition evaluation, and the E->M pipeline register with valid/ready.
module execute_cc_stage #(
  parameter int         N     = 64,
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [3:0]   icode_i,
  input  logic [3:0]   ifun_i,
  input  logic [N-1:0] alu_a_i,
  input  logic [N-1:0] alu_b_i,
  input  logic [N-1:0] alu_result_i,
  input  logic [N-1:0] val_a_i,
  input  logic [3:0]   dst_e_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [3:0]   out_icode_o,
  output logic [N-1:0] out_val_e_o,
  output logic [N-1:0] out_val_a_o,
  output logic [3:0]   out_dst_e_o,
  output logic         out_cnd_o,
  output logic         cc_zf_o,
  output logic         cc_sf_o,
  output logic         cc_of_o
);

  localparam logic [3:0] ICODE_CMOV = 4'd2;
  localparam logic [3:0] ICODE_OPQ  = 4'd6;
  localparam logic [3:0] ICODE_JXX  = 4'd7;

  logic         zf_q, sf_q, of_q;
  logic         zf_d, sf_d, of_d;
  logic         valid_q, valid_d;
  logic [3:0]   icode_q, icode_d;
  logic [N-1:0] val_e_q, val_e_d;
  logic [N-1:0] val_a_q, val_a_d;
  logic [3:0]   dst_e_q, dst_e_d;
  logic         cnd_q, cnd_d;

  logic acc;
  logic cnd;
  logic cc_we;
  logic sf_x_of;
  logic op_of;

  assign in_ready_o = ~valid_q | out_ready_i;
  assign acc        = in_valid_i & in_ready_o & ~flush_i;

  // Condition evaluated against the CC value held before this cycle's update.
  always_comb begin
    cnd     = 1'b0;
    sf_x_of = sf_q ^ of_q;
    case (ifun_i)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = sf_x_of | zf_q;
      4'd2:    cnd = sf_x_of;
      4'd3:    cnd = zf_q;
      4'd4:    cnd = ~zf_q;
      4'd5:    cnd = ~sf_x_of;
      4'd6:    cnd = ~sf_x_of & ~zf_q;
      default: cnd = 1'b0;
    endcase
    if (!(icode_i == ICODE_CMOV || icode_i == ICODE_JXX)) begin
      cnd = 1'b0;
    end
  end

  // Next CC value; only OPq with a real ALU op (0..3) writes the flags.
  always_comb begin
    cc_we = acc && (icode_i == ICODE_OPQ) && (ifun_i <= 4'd3);
    op_of = 1'b0;
    case (ifun_i[1:0])
      2'd0:    op_of = (alu_a_i[N-1] == alu_b_i[N-1]) && (alu_result_i[N-1] != alu_a_i[N-1]);
      2'd1:    op_of = (alu_a_i[N-1] != alu_b_i[N-1]) && (alu_result_i[N-1] != alu_a_i[N-1]);
      default: op_of = 1'b0;
    endcase
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (cc_we) begin
      zf_d = (alu_result_i == '0);
      sf_d = alu_result_i[N-1];
      of_d = op_of;
    end
  end

  // Output register next state: flush squashes, accept loads, consume drains.
  always_comb begin
    valid_d = valid_q;
    icode_d = icode_q;
    val_e_d = val_e_q;
    val_a_d = val_a_q;
    dst_e_d = dst_e_q;
    cnd_d   = cnd_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (acc) begin
      valid_d = 1'b1;
      icode_d = icode_i;
      val_e_d = alu_result_i;
      val_a_d = val_a_i;
      dst_e_d = (icode_i == ICODE_CMOV && !cnd) ? RNONE : dst_e_i;
      cnd_d   = cnd;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
      valid_q <= 1'b0;
      icode_q <= 4'd0;
      val_e_q <= '0;
      val_a_q <= '0;
      dst_e_q <= RNONE;
      cnd_q   <= 1'b0;
    end else begin
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
      valid_q <= valid_d;
      icode_q <= icode_d;
      val_e_q <= val_e_d;
      val_a_q <= val_a_d;
      dst_e_q <= dst_e_d;
      cnd_q   <= cnd_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_icode_o = icode_q;
  assign out_val_e_o = val_e_q;
  assign out_val_a_o = val_a_q;
  assign out_dst_e_o = dst_e_q;
  assign out_cnd_o   = cnd_q;
  assign cc_zf_o     = zf_q;
  assign cc_sf_o     = sf_q;
  assign cc_of_o     = of_q;

endmodule

// File: tb/tb_execute_cc_stage.sv
// Bench for execute_cc_stage: directed scenarios followed by random traffic,
// all checked against a flag/queue-level reference model.
module tb_execute_cc_stage;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   icode, ifun, dst_e, out_icode, out_dst_e;
  logic [N-1:0] alu_a, alu_b, alu_result, val_a, out_val_e, out_val_a;
  logic         out_cnd, cc_zf, cc_sf, cc_of;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic         m_valid, m_cnd, m_zf, m_sf, m_of, m_rst_seen;
  logic [3:0]   m_icode, m_dst;
  logic [N-1:0] m_vale, m_vala;

  always #5 clk = ~clk;

  execute_cc_stage #(.N(N), .RNONE(4'hF)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .icode_i(icode), .ifun_i(ifun),
    .alu_a_i(alu_a), .alu_b_i(alu_b), .alu_result_i(alu_result),
    .val_a_i(val_a), .dst_e_i(dst_e),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_icode_o(out_icode), .out_val_e_o(out_val_e), .out_val_a_o(out_val_a),
    .out_dst_e_o(out_dst_e), .out_cnd_o(out_cnd),
    .cc_zf_o(cc_zf), .cc_sf_o(cc_sf), .cc_of_o(cc_of)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] alu(input logic [3:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Signed overflow: the exact (N+1)-bit signed result does not fit in N bits.
  function automatic logic ref_of(input logic [3:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [N:0] w;
    if (f == 4'd0)      w = $signed({a[N-1], a}) + $signed({b[N-1], b});
    else if (f == 4'd1) w = $signed({a[N-1], a}) - $signed({b[N-1], b});
    else return 1'b0;
    return w[N] ^ w[N-1];
  endfunction

  function automatic logic ref_cond(input logic [3:0] f, input logic zf, input logic sf, input logic of);
    logic less;
    less = (sf != of);
    case (f)
      4'd0:    return 1'b1;
      4'd1:    return less || zf;
      4'd2:    return less;
      4'd3:    return zf;
      4'd4:    return !zf;
      4'd5:    return !less;
      4'd6:    return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_icode = 4'd0; m_vale = '0; m_vala = '0;
    m_dst = 4'hF; m_cnd = 1'b0; m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] va, input logic [3:0] de);
    in_valid = v; icode = ic; ifun = fn; alu_a = a; alu_b = b; val_a = va; dst_e = de;
    alu_result = (ic == 4'd6 && fn <= 4'd3) ? alu(fn, a, b) : {$urandom, $urandom};
  endtask

  // One clock: predict, advance, then compare everything observable.
  task automatic cycle();
    logic rdy, acc, c;
    #1;
    rdy = !m_valid || out_ready;
    if (!rst) chk("in_ready", 64'(in_ready), 64'(rdy));
    acc = in_valid && rdy && !flush;
    c = (icode == 4'd2 || icode == 4'd7) ? ref_cond(ifun, m_zf, m_sf, m_of) : 1'b0;
    @(posedge clk);
    m_rst_seen = rst;
    if (rst) begin
      model_reset();
    end else begin
      if (acc && icode == 4'd6 && ifun <= 4'd3) begin
        m_zf = (alu_result == '0);
        m_sf = alu_result[N-1];
        m_of = ref_of(ifun, alu_a, alu_b);
      end
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1; m_icode = icode; m_vale = alu_result; m_vala = val_a;
        m_cnd = c; m_dst = (icode == 4'd2 && !c) ? 4'hF : dst_e;
      end else if (out_ready) m_valid = 1'b0;
    end
    @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid || m_rst_seen) begin
      chk("out_icode", 64'(out_icode), 64'(m_icode));
      chk("out_val_e", out_val_e, m_vale);
      chk("out_val_a", out_val_a, m_vala);
      chk("out_dst_e", 64'(out_dst_e), 64'(m_dst));
      chk("out_cnd", 64'(out_cnd), 64'(m_cnd));
    end
    chk("cc_zf", 64'(cc_zf), 64'(m_zf));
    chk("cc_sf", 64'(cc_sf), 64'(m_sf));
    chk("cc_of", 64'(cc_of), 64'(m_of));
  endtask

  initial begin
    logic [N-1:0] a, b, hold_e;
    logic [3:0] ic, fn;
    int sel;
    model_reset();
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'd0, 4'd0, '0, '0, '0, 4'd0);
    @(negedge clk);

    // 1: reset, then je on reset flags
    cycle();
    rst = 1'b0;
    chk("t1_rst_valid", 64'(out_valid), 64'd0);
    chk("t1_rst_zf", 64'(cc_zf), 64'd1);
    chk("t1_rst_dst", 64'(out_dst_e), 64'hF);
    drive(1'b1, 4'd7, 4'd3, '0, '0, 64'h11, 4'hF);
    cycle();
    chk("t1_je_cnd", 64'(out_cnd), 64'd1);

    // 2: signed overflow on add, then jl
    drive(1'b1, 4'd6, 4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'd2);
    cycle();
    chk("t2_val_e", out_val_e, 64'h8000_0000_0000_0000);
    chk("t2_flags", 64'({cc_zf, cc_sf, cc_of}), 64'b011);
    drive(1'b1, 4'd7, 4'd2, '0, '0, '0, 4'hF);
    cycle();
    chk("t2_jl_cnd", 64'(out_cnd), 64'd0);

    // 3: sub to zero, then cmovne squashes the destination
    drive(1'b1, 4'd6, 4'd1, 64'd5, 64'd5, 64'd0, 4'd1);
    cycle();
    chk("t3_flags", 64'({cc_zf, cc_sf, cc_of}), 64'b100);
    drive(1'b1, 4'd2, 4'd4, 64'd9, 64'd0, 64'd9, 4'd3);
    cycle();
    chk("t3_cmov_cnd", 64'(out_cnd), 64'd0);
    chk("t3_cmov_dst", 64'(out_dst_e), 64'hF);

    // 4: backpressure holds the bundle; release lets the next one in
    out_ready = 1'b0;
    drive(1'b1, 4'd6, 4'd0, 64'd100, 64'd23, 64'hAA, 4'd4);
    cycle();
    hold_e = out_val_e;
    drive(1'b1, 4'd6, 4'd2, 64'hF0F0, 64'h0FF0, 64'hBB, 4'd5);
    repeat (3) cycle();
    chk("t4_in_ready_low", 64'(in_ready), 64'd0);
    chk("t4_hold_val_e", out_val_e, hold_e);
    out_ready = 1'b1;
    cycle();
    chk("t4_new_val_e", out_val_e, 64'h00F0);

    // 5: flush drops an xor-to-zero, flags keep ZF=0 from the add before it
    drive(1'b1, 4'd6, 4'd0, 64'd1, 64'd1, 64'd0, 4'd6);
    cycle();
    flush = 1'b1;
    drive(1'b1, 4'd6, 4'd3, 64'h1234, 64'h1234, 64'd0, 4'd7);
    cycle();
    flush = 1'b0;
    chk("t5_flush_valid", 64'(out_valid), 64'd0);
    chk("t5_flush_zf", 64'(cc_zf), 64'd0);

    // 6: streaming of 4 OPq at full throughput
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd6, 4'(i), {$urandom, $urandom}, {$urandom, $urandom}, 64'(i), 4'(i));
      cycle();
    end
    drive(1'b0, 4'd0, 4'd0, '0, '0, '0, 4'd0);
    cycle();

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 63) == 0);
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 7);
      ic = (sel <= 2) ? 4'd6 : (sel <= 4) ? 4'd7 : (sel == 5) ? 4'd2 : 4'($urandom);
      fn = (ic == 4'd6) ? 4'($urandom_range(0, 5)) : 4'($urandom_range(0, 9));
      a = {$urandom, $urandom};
      b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
      drive($urandom_range(0, 3) != 0, ic, fn, a, b, {$urandom, $urandom}, 4'($urandom));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
